window_3x3_gen: RTL and testbench

//   Converts a raster-order 8-bit pixel stream into a sliding 3x3 neighbourhood.

---
 rtl/window_3x3_gen.sv | 122 ++++++++++++
 tb/tb_window_3x3_gen.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_3x3_gen.sv
// Sliding 3x3 neighbourhood generator for a raster-order pixel stream.
// Two line buffers hold the previous two rows; one window is emitted per accepted pixel.
module window_3x3_gen #(
    parameter int DATA_W     = 8,
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_pixel,
    output logic              out_valid,
    output logic [DATA_W-1:0] w1,
    output logic [DATA_W-1:0] w2,
    output logic [DATA_W-1:0] w3,
    output logic [DATA_W-1:0] w4,
    output logic [DATA_W-1:0] w5,
    output logic [DATA_W-1:0] w6,
    output logic [DATA_W-1:0] w7,
    output logic [DATA_W-1:0] w8,
    output logic [DATA_W-1:0] w9,
    output logic              frame_done
);

    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              out_valid_q, out_valid_d;
    logic              frame_done_q, frame_done_d;
    logic [DATA_W-1:0] win_q [9];
    logic [DATA_W-1:0] win_d [9];

    logic [DATA_W-1:0] lb0_q [IMG_WIDTH];
    logic [DATA_W-1:0] lb1_q [IMG_WIDTH];
    logic [DATA_W-1:0] lb0_rd;
    logic [DATA_W-1:0] lb1_rd;

    assign lb0_rd = lb0_q[col_q];
    assign lb1_rd = lb1_q[col_q];

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        for (int i = 0; i < 9; i++) begin
            win_d[i] = win_q[i];
        end

        if (in_valid) begin
            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
            win_d[2] = lb1_rd;
            win_d[3] = win_q[4];
            win_d[4] = win_q[5];
            win_d[5] = lb0_rd;
            win_d[6] = win_q[7];
            win_d[7] = win_q[8];
            win_d[8] = in_pixel;

            // Windows straddling a row wrap or the top two rows are never flagged.
            out_valid_d = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d        = '0;
                    frame_done_d = 1'b1;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    // Line-buffer RAM is deliberately unreset; the row gate masks stale contents.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb1_q[col_q] <= lb0_rd;
            lb0_q[col_q] <= in_pixel;
        end
    end

    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign w1 = win_q[0];
    assign w2 = win_q[1];
    assign w3 = win_q[2];
    assign w4 = win_q[3];
    assign w5 = win_q[4];
    assign w6 = win_q[5];
    assign w7 = win_q[6];
    assign w8 = win_q[7];
    assign w9 = win_q[8];

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen on a 4x4 image with pixel value = row*4+col.
module tb_window_3x3_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_pixel;
    logic       out_valid;
    logic [7:0] w1, w2, w3, w4, w5, w6, w7, w8, w9;
    logic       frame_done;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] expWin [4][9];

    window_3x3_gen #(
        .DATA_W    (8),
        .IMG_WIDTH (4),
        .IMG_HEIGHT(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_pixel  (in_pixel),
        .out_valid (out_valid),
        .w1        (w1),
        .w2        (w2),
        .w3        (w3),
        .w4        (w4),
        .w5        (w5),
        .w6        (w6),
        .w7        (w7),
        .w8        (w8),
        .w9        (w9),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [71:0] expPacked(input int k, input int off);
        logic [71:0] r;
        r = '0;
        for (int i = 0; i < 9; i++) begin
            r[71-8*i -: 8] = expWin[k][i] + 8'(off);
        end
        return r;
    endfunction

    function automatic logic [71:0] obsPacked();
        return {w1, w2, w3, w4, w5, w6, w7, w8, w9};
    endfunction

    // Pixel accepted on the next rising edge; outputs sampled 1 time unit later.
    task automatic push(input logic [7:0] v);
        @(negedge clk);
        in_valid = 1'b1;
        in_pixel = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_pixel = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        compared++;
        if (frame_done !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_frame_done: got %b want 0", frame_done);
        end
        compared++;
        if (obsPacked() !== 72'h0) begin
            mismatched++;
            $display("FAIL reset_window: got %h want 0", obsPacked());
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        compared++;
        if (out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL idle_after_reset: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_continuous();
        int  k;
        logic expV;
        k = 0;
        for (int p = 0; p < 16; p++) begin
            push(8'(p));
            expV = ((p % 4) >= 2) && ((p / 4) >= 2);
            compared++;
            if (out_valid !== expV) begin
                mismatched++;
                $display("FAIL cont_valid p=%0d: got %b want %b", p, out_valid, expV);
            end
            if (expV) begin
                compared++;
                if (obsPacked() !== expPacked(k, 0)) begin
                    mismatched++;
                    $display("FAIL cont_window %0d: got %h want %h", k, obsPacked(), expPacked(k, 0));
                end
                k++;
            end
            compared++;
            if (frame_done !== (p == 15)) begin
                mismatched++;
                $display("FAIL cont_frame_done p=%0d: got %b want %b", p, frame_done, (p == 15));
            end
        end
        idle();
        compared++;
        if (frame_done !== 1'b0 || out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL cont_pulse_width: frame_done=%b out_valid=%b want 0 0", frame_done, out_valid);
        end
    endtask

    task automatic test_gaps();
        int  k;
        int  gap;
        logic expV;
        k = 0;
        for (int p = 0; p < 16; p++) begin
            push(8'(p));
            expV = ((p % 4) >= 2) && ((p / 4) >= 2);
            compared++;
            if (out_valid !== expV) begin
                mismatched++;
                $display("FAIL gap_valid p=%0d: got %b want %b", p, out_valid, expV);
            end
            if (expV) begin
                compared++;
                if (obsPacked() !== expPacked(k, 0)) begin
                    mismatched++;
                    $display("FAIL gap_window %0d: got %h want %h", k, obsPacked(), expPacked(k, 0));
                end
                k++;
            end
            compared++;
            if (frame_done !== (p == 15)) begin
                mismatched++;
                $display("FAIL gap_frame_done p=%0d: got %b want %b", p, frame_done, (p == 15));
            end
            gap = $urandom_range(1, 5);
            for (int g = 0; g < gap; g++) begin
                idle();
                compared++;
                if (out_valid !== 1'b0 || frame_done !== 1'b0) begin
                    mismatched++;
                    $display("FAIL gap_idle p=%0d: out_valid=%b frame_done=%b want 0 0", p, out_valid, frame_done);
                end
                // The window must hold its last valid contents through an idle gap.
                if (expV) begin
                    compared++;
                    if (obsPacked() !== expPacked(k - 1, 0)) begin
                        mismatched++;
                        $display("FAIL gap_hold p=%0d: got %h want %h", p, obsPacked(), expPacked(k - 1, 0));
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int  k;
        logic expV;
        for (int f = 0; f < 2; f++) begin
            k = 0;
            for (int p = 0; p < 16; p++) begin
                push(8'(p + 100 * f));
                expV = ((p % 4) >= 2) && ((p / 4) >= 2);
                compared++;
                if (out_valid !== expV) begin
                    mismatched++;
                    $display("FAIL b2b_valid f=%0d p=%0d: got %b want %b", f, p, out_valid, expV);
                end
                if (expV) begin
                    compared++;
                    if (obsPacked() !== expPacked(k, 100 * f)) begin
                        mismatched++;
                        $display("FAIL b2b_window f=%0d k=%0d: got %h want %h", f, k, obsPacked(), expPacked(k, 100 * f));
                    end
                    k++;
                end
                compared++;
                if (frame_done !== (p == 15)) begin
                    mismatched++;
                    $display("FAIL b2b_frame_done f=%0d p=%0d: got %b want %b", f, p, frame_done, (p == 15));
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int  k;
        logic expV;
        for (int p = 0; p < 7; p++) begin
            push(8'(p));
        end
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if (obsPacked() !== 72'h0) begin
            mismatched++;
            $display("FAIL midrst_window: got %h want 0", obsPacked());
        end
        compared++;
        if (out_valid !== 1'b0 || frame_done !== 1'b0) begin
            mismatched++;
            $display("FAIL midrst_flags: out_valid=%b frame_done=%b want 0 0", out_valid, frame_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        for (int p = 0; p < 16; p++) begin
            push(8'(p));
            expV = ((p % 4) >= 2) && ((p / 4) >= 2);
            compared++;
            if (out_valid !== expV) begin
                mismatched++;
                $display("FAIL midrst_valid p=%0d: got %b want %b", p, out_valid, expV);
            end
            if (expV) begin
                compared++;
                if (obsPacked() !== expPacked(k, 0)) begin
                    mismatched++;
                    $display("FAIL midrst_frame_window %0d: got %h want %h", k, obsPacked(), expPacked(k, 0));
                end
                k++;
            end
            compared++;
            if (frame_done !== (p == 15)) begin
                mismatched++;
                $display("FAIL midrst_frame_done p=%0d: got %b want %b", p, frame_done, (p == 15));
            end
        end
    endtask

    initial begin
        expWin[0] = '{8'd0, 8'd1, 8'd2,  8'd4, 8'd5,  8'd6,  8'd8,  8'd9,  8'd10};
        expWin[1] = '{8'd1, 8'd2, 8'd3,  8'd5, 8'd6,  8'd7,  8'd9,  8'd10, 8'd11};
        expWin[2] = '{8'd4, 8'd5, 8'd6,  8'd8, 8'd9,  8'd10, 8'd12, 8'd13, 8'd14};
        expWin[3] = '{8'd5, 8'd6, 8'd7,  8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15};

        test_reset();
        test_continuous();
        test_gaps();
        test_back_to_back();
        test_reset_mid_frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
